lcd_fifo_rd_sched: RTL and testbench
====================================

Name: lcd_fifo_rd_sched

Overview:
- Read-side scheduler for the LCD pixel FIFO, running in the rd_clk (pixel clock) domain.
- Generates LCD raster timing (hs/vs/de) from programmable porch and sync parameters.
- Pops one FIFO word per active pixel through the first-word-fall-through read handshake (rd_data/rd_vld/rd_en).
- Reports underflow and gives the upstream frame writer a frame-start pulse.

Parameters:
- DATA_W, 32, pixel/FIFO word width.
- H_SYNC, 10, hsync width in clocks.
- H_BP, 20, horizontal back porch.
- H_ACTIVE, 480, active pixels per line.
- H_FP, 10, horizontal front porch.
- V_SYNC, 2, vsync width in lines.
- V_BP, 10, vertical back porch.
- V_ACTIVE, 272, active lines.
- V_FP, 4, vertical front porch.
- UF_COLOR, 0, pixel value output on underflow.

Ports:
- rd_clk  in  1  pixel clock, same clock as FIFO read side.
- rd_rst  in  1  asynchronous active-high reset.
- enable  in  1  level; 1 = run display, 0 = stop at end of frame.
- fifo_rd_data  in  DATA_W  FIFO head word.
- fifo_rd_vld  in  1  FIFO head valid.
- fifo_rd_en  out  DATA_W-independent 1  pop request; a pop occurs when fifo_rd_en & fifo_rd_vld.
- lcd_hs  out  1  hsync, active low.
- lcd_vs  out  1  vsync, active low.
- lcd_de  out  1  data enable, active high.
- lcd_data  out  DATA_W  pixel.
- frame_start  out  1  one-cycle pulse at frame origin.
- uf_clr  in  1  clears underflow flag and count.
- uf_flag  out  1  sticky underflow.
- uf_cnt  out  16  underflow pixel count, saturating at 0xFFFF.
- busy  out  1  high in states other than IDLE.

Behaviour:
- Reset state: all outputs go to inactive values.
  - lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_data=0.
  - fifo_rd_en=0, frame_start=0, uf_flag=0, uf_cnt=0, busy=0.
  - State=IDLE, h_cnt=0, v_cnt=0.
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Counter widths are clog2 of the totals.
- Horizontal regions by h_cnt:
  - [0, H_SYNC) sync.
  - [H_SYNC, H_SYNC+H_BP) back porch.
  - next H_ACTIVE counts active.
  - remainder front porch.
  - Vertical regions use v_cnt with the same ordering.
- Counter stepping:
  - h_cnt wraps at H_TOTAL-1 to 0.
  - v_cnt increments only on h_cnt wrap and wraps at V_TOTAL-1 to 0.
- State machine:
  - IDLE: counters held at 0; outputs inactive. enable=1 -> FILL.
  - FILL: counters held. fifo_rd_vld=1 -> RUN. enable=0 -> IDLE.
  - RUN: counters advance every cycle.
    - At the last count of a frame (h=H_TOTAL-1, v=V_TOTAL-1): enable=0 -> IDLE; otherwise stay in RUN.
    - enable dropping mid-frame does not truncate the frame.
- Active and pop: act = h_active & v_active in RUN. fifo_rd_en = act (combinational from state and counters).
- Output pipeline (all outputs registered, latency 1 cycle from counters):
  - lcd_hs = ~h_sync; lcd_vs = ~v_sync; lcd_de = act.
  - lcd_data = fifo_rd_data if act & fifo_rd_vld.
  - lcd_data = UF_COLOR if act & ~fifo_rd_vld.
  - lcd_data = 0 when ~act.
- Underflow: act & ~fifo_rd_vld sets uf_flag and increments uf_cnt (saturating).
  - The pixel position is consumed; no stall, no resync.
  - The next word pops at the next active pixel.
- uf_clr has priority over a same-cycle underflow increment: clear wins, and that event is lost.
- frame_start: registered pulse in the cycle after counters are at (0,0) in RUN, i.e. aligned with the first cycle of lcd_vs low.
  - The FILL->RUN entry counts as (0,0).
- Boundary rules:
  - FIFO empty during blanking: no effect.
  - fifo_rd_vld toggling mid-line is handled per pixel.
- rd_rst mid-operation: immediate return to reset values; the FIFO is not popped during reset.

Test Plan (params H_SYNC=1, H_BP=1, H_ACTIVE=4, H_FP=1, V_SYNC=1, V_BP=1, V_ACTIVE=2, V_FP=1 -> 7x5 = 35 clocks/frame; DATA_W=8, UF_COLOR=8'hEE):
- Reset, then enable=1 with FIFO preloaded 8 words 0x01..0x08:
  - FILL->RUN after 1 cycle; frame_start pulses once.
  - First lcd_de occurs 17 clocks after RUN entry; lcd_data=01,02,03,04 on line 2 and 05..08 on line 3.
  - Exactly 8 pops per frame; lcd_hs low 1 clock per line; lcd_vs low 7 clocks per frame.
- Enable=1 with empty FIFO: stays in FILL, busy=1, no hs/vs activity; write one word -> RUN next cycle.
- FIFO holds 6 words for one frame:
  - Last 2 active pixels show 0xEE; uf_flag=1, uf_cnt=2.
  - uf_clr pulse -> both 0 next cycle.
- Drop enable at clock 10 of a frame: full 35-clock frame completes, then IDLE; busy=0; hs=vs=1, de=0 thereafter.
- Assert rd_rst at clock 18 (mid active line): all outputs at reset values immediately; no pops until enable re-run.
- Force 65540 underflow pixels: uf_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/lcd_fifo_rd_sched.sv
// LCD read-side scheduler: raster timing generator plus FWFT FIFO pop control
// in the pixel clock domain. It pops one word per active pixel, substitutes
// UF_COLOR on underflow and tracks underflow events.
module lcd_fifo_rd_sched #(
    parameter int DATA_W   = 32,
    parameter int H_SYNC   = 10,
    parameter int H_BP     = 20,
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 10,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 4,
    parameter logic [DATA_W-1:0] UF_COLOR = '0
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_vld,
    output logic              fifo_rd_en,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_de,
    output logic [DATA_W-1:0] lcd_data,
    output logic              frame_start,
    input  logic              uf_clr,
    output logic              uf_flag,
    output logic [15:0]       uf_cnt,
    output logic              busy
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    // Region edges kept as int so an edge equal to the total (zero front
    // porch) is not truncated by the narrow counter width.
    localparam int H_A0 = H_SYNC + H_BP;
    localparam int H_A1 = H_A0 + H_ACTIVE;
    localparam int V_A0 = V_SYNC + V_BP;
    localparam int V_A1 = V_A0 + V_ACTIVE;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic              w_run;
    logic              w_busy;

    logic [HW-1:0]     r_h_cnt;
    logic [VW-1:0]     r_v_cnt;
    logic [31:0]       w_h32;
    logic [31:0]       w_v32;
    logic              w_last_h;
    logic              w_last_v;
    logic              w_h_sync;
    logic              w_v_sync;
    logic              w_h_act;
    logic              w_v_act;
    logic              w_act;
    logic              w_origin;

    logic              r_hs;
    logic              r_vs;
    logic              r_de;
    logic [DATA_W-1:0] r_data;
    logic              r_fs;
    logic              r_uf_flag;
    logic [15:0]       r_uf_cnt;

    assign w_h32    = 32'(r_h_cnt);
    assign w_v32    = 32'(r_v_cnt);
    assign w_last_h = (r_h_cnt == H_LAST);
    assign w_last_v = (r_v_cnt == V_LAST);
    assign w_h_sync = (w_h32 < H_SYNC);
    assign w_v_sync = (w_v32 < V_SYNC);
    assign w_h_act  = (w_h32 >= H_A0) && (w_h32 < H_A1);
    assign w_v_act  = (w_v32 >= V_A0) && (w_v32 < V_A1);
    assign w_act    = w_run & w_h_act & w_v_act;
    assign w_origin = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);

    // Pop is combinational so the FWFT head is consumed in the same cycle
    // the pixel position is scanned.
    assign fifo_rd_en  = w_act;
    assign lcd_hs      = r_hs;
    assign lcd_vs      = r_vs;
    assign lcd_de      = r_de;
    assign lcd_data    = r_data;
    assign frame_start = r_fs;
    assign uf_flag     = r_uf_flag;
    assign uf_cnt      = r_uf_cnt;
    assign busy        = w_busy;

    // State register
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    // Next-state: a frame, once started, always runs to its last count
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: if (enable) w_nxt = S_FILL;
            S_FILL: begin
                if (fifo_rd_vld)  w_nxt = S_RUN;
                else if (!enable) w_nxt = S_IDLE;
            end
            S_RUN:  if (w_last_h && w_last_v && !enable) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_run  = (r_state == S_RUN);
        w_busy = (r_state != S_IDLE);
    end

    // Raster counters: held at the origin outside RUN, free-running inside
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_last_h) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_last_v ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    // Registered LCD outputs, one cycle behind the counters
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
            r_de   <= 1'b0;
            r_data <= '0;
            r_fs   <= 1'b0;
        end else begin
            r_hs <= ~(w_run & w_h_sync);
            r_vs <= ~(w_run & w_v_sync);
            r_de <= w_act;
            r_fs <= w_origin;
            if (!w_act)          r_data <= '0;
            else if (fifo_rd_vld) r_data <= fifo_rd_data;
            else                 r_data <= UF_COLOR;
        end
    end

    // Underflow tracking; a same-cycle clear discards the new event
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_uf_flag <= 1'b0;
            r_uf_cnt  <= '0;
        end else if (uf_clr) begin
            r_uf_flag <= 1'b0;
            r_uf_cnt  <= '0;
        end else if (w_act && !fifo_rd_vld) begin
            r_uf_flag <= 1'b1;
            if (r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lcd_fifo_rd_sched.sv
// Bench for lcd_fifo_rd_sched: small 7x5 raster with an FWFT FIFO model and a
// pixel scoreboard, plus a large mostly-active raster for counter saturation.
module tb_lcd_fifo_rd_sched;

    logic       rd_clk;
    logic       rd_rst;
    logic       enable;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_vld;
    logic       fifo_rd_en;
    logic       lcd_hs, lcd_vs, lcd_de;
    logic [7:0] lcd_data;
    logic       frame_start;
    logic       uf_clr;
    logic       uf_flag;
    logic [15:0] uf_cnt;
    logic       busy;

    // saturation instance signals
    logic       s_rst, s_en, s_vld, s_rd_en, s_hs, s_vs, s_de, s_fs, s_flag, s_busy;
    logic [7:0] s_data, s_lcd;
    logic [15:0] s_cnt;

    lcd_fifo_rd_sched #(
        .DATA_W(8), .H_SYNC(1), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1), .UF_COLOR(8'hEE)
    ) u_dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en),
        .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_data(lcd_data),
        .frame_start(frame_start), .uf_clr(uf_clr), .uf_flag(uf_flag),
        .uf_cnt(uf_cnt), .busy(busy)
    );

    lcd_fifo_rd_sched #(
        .DATA_W(8), .H_SYNC(1), .H_BP(1), .H_ACTIVE(254), .H_FP(0),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(254), .V_FP(0), .UF_COLOR(8'hEE)
    ) u_sat (
        .rd_clk(rd_clk), .rd_rst(s_rst), .enable(s_en),
        .fifo_rd_data(s_data), .fifo_rd_vld(s_vld), .fifo_rd_en(s_rd_en),
        .lcd_hs(s_hs), .lcd_vs(s_vs), .lcd_de(s_de), .lcd_data(s_lcd),
        .frame_start(s_fs), .uf_clr(1'b0), .uf_flag(s_flag),
        .uf_cnt(s_cnt), .busy(s_busy)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // FWFT FIFO model: initial block writes, pop side advances on posedge
    logic [7:0] fmem [0:63];
    int wp = 0;
    int rp = 0;
    int pop_n = 0;
    assign fifo_rd_vld  = (wp != rp);
    assign fifo_rd_data = fmem[rp % 64];

    always @(posedge rd_clk) begin
        if (fifo_rd_en && fifo_rd_vld) begin
            rp    <= rp + 1;
            pop_n <= pop_n + 1;
        end
    end

    // Output monitor: captures pixels and counts sync activity
    logic [7:0] obs_mem [0:255];
    int obs_n = 0;
    int hs_n = 0, vs_n = 0, fs_n = 0, de_n = 0;

    always @(negedge rd_clk) begin
        if (lcd_de) begin
            obs_mem[obs_n % 256] = lcd_data;
            obs_n = obs_n + 1;
            de_n  = de_n + 1;
        end
        if (!lcd_hs)    hs_n = hs_n + 1;
        if (!lcd_vs)    vs_n = vs_n + 1;
        if (frame_start) fs_n = fs_n + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int obs_rd  = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge rd_clk);
    endtask

    task automatic push_word(input logic [7:0] d);
        fmem[wp % 64] = d;
        wp = wp + 1;
    endtask

    task automatic wait_fs();
        int k = 0;
        while (!frame_start && k < 100) begin tick(1); k++; end
        chk("fs_seen", 32'(frame_start), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin tick(1); k++; end
        chk("idle_reached", 32'(busy), 0);
    endtask

    // compare captured pixels against the expectation queue
    task automatic drain();
        logic [7:0] e;
        chk("pix_count", obs_n - obs_rd, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_n) begin
                chk("pix", 32'(obs_mem[obs_rd % 256]), 32'(e));
                obs_rd++;
            end
        end
        obs_rd = obs_n;
    endtask

    // saturation run in parallel: enter RUN with one valid cycle, then starve
    logic sat_done = 1'b0;
    logic sat_hit  = 1'b0;
    logic [15:0] sat_final = '0;
    initial begin
        s_rst = 1'b1; s_en = 1'b0; s_vld = 1'b0; s_data = 8'hA5;
        tick(2);
        s_rst = 1'b0; s_en = 1'b1; s_vld = 1'b1;
        tick(2);
        s_vld = 1'b0;
        for (int k = 0; k < 70000 && s_cnt != 16'hFFFF; k++) tick(1);
        sat_hit = (s_cnt == 16'hFFFF);
        tick(600);
        sat_final = s_cnt;
        sat_done  = 1'b1;
    end

    initial begin
        int c, de_first, fs_c, idle_c, k;
        int hs0, vs0, fs0, de0, p0;
        rd_rst = 1'b1; enable = 1'b0; uf_clr = 1'b0;
        tick(2);
        // reset state
        chk("rst_hs", 32'(lcd_hs), 1);
        chk("rst_vs", 32'(lcd_vs), 1);
        chk("rst_de", 32'(lcd_de), 0);
        chk("rst_data", 32'(lcd_data), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_uf_flag", 32'(uf_flag), 0);
        chk("rst_uf_cnt", 32'(uf_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rd_rst = 1'b0;
        tick(1);

        // full frame with 8 preloaded words, enable dropped mid-frame
        for (int i = 1; i <= 8; i++) begin push_word(8'(i)); exp_q.push_back(8'(i)); end
        hs0 = hs_n; vs0 = vs_n; fs0 = fs_n; de0 = de_n; p0 = pop_n;
        enable = 1'b1;
        tick(1);
        chk("fill_busy", 32'(busy), 1);
        tick(1);
        c = 0; de_first = -1; fs_c = -1; idle_c = -1;
        while (c < 100 && idle_c < 0) begin
            tick(1); c++;
            if (lcd_de && de_first < 0) de_first = c;
            if (frame_start && fs_c < 0) fs_c = c;
            if (c == 10) enable = 1'b0;
            if (!busy) idle_c = c;
        end
        chk("de_latency", de_first, 17);
        chk("fs_cycle", fs_c, 1);
        chk("frame_len", idle_c, 35);
        chk("hs_low_clks", hs_n - hs0, 5);
        chk("vs_low_clks", vs_n - vs0, 7);
        chk("fs_pulses", fs_n - fs0, 1);
        chk("pops", pop_n - p0, 8);
        chk("de_clks", de_n - de0, 8);
        tick(3);
        chk("idle_hs", 32'(lcd_hs), 1);
        chk("idle_vs", 32'(lcd_vs), 1);
        chk("idle_de", 32'(lcd_de), 0);
        chk("idle_no_hs", hs_n - hs0, 5);
        drain();

        // empty FIFO: waits in FILL with no raster activity
        hs0 = hs_n; vs0 = vs_n; p0 = pop_n;
        enable = 1'b1;
        tick(5);
        chk("fill_wait_busy", 32'(busy), 1);
        chk("fill_wait_hs", hs_n - hs0, 0);
        chk("fill_wait_vs", vs_n - vs0, 0);
        chk("fill_wait_pops", pop_n - p0, 0);
        push_word(8'h55);
        exp_q.push_back(8'h55);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'hEE);
        tick(2);
        chk("fs_after_word", 32'(frame_start), 1);
        enable = 1'b0;
        wait_idle();
        drain();
        chk("uf1_flag", 32'(uf_flag), 1);
        chk("uf1_cnt", 32'(uf_cnt), 7);
        uf_clr = 1'b1; tick(1); uf_clr = 1'b0;
        chk("clr1_flag", 32'(uf_flag), 0);
        chk("clr1_cnt", 32'(uf_cnt), 0);

        // six words for eight pixels: last two are underflow colour
        for (int i = 0; i < 6; i++) begin push_word(8'h11 + 8'(i)); exp_q.push_back(8'h11 + 8'(i)); end
        exp_q.push_back(8'hEE); exp_q.push_back(8'hEE);
        enable = 1'b1;
        wait_fs();
        enable = 1'b0;
        wait_idle();
        drain();
        chk("uf2_flag", 32'(uf_flag), 1);
        chk("uf2_cnt", 32'(uf_cnt), 2);

        // clear coinciding with the first underflow pixel: clear wins
        push_word(8'h77);
        exp_q.push_back(8'h77);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'hEE);
        enable = 1'b1;
        wait_fs();
        tick(16);
        chk("de_at_17", 32'(lcd_de), 1);
        uf_clr = 1'b1; tick(1); uf_clr = 1'b0;
        enable = 1'b0;
        wait_idle();
        drain();
        chk("uf3_cnt", 32'(uf_cnt), 6);
        chk("uf3_flag", 32'(uf_flag), 1);
        uf_clr = 1'b1; tick(1); uf_clr = 1'b0;
        chk("clr2_flag", 32'(uf_flag), 0);
        chk("clr2_cnt", 32'(uf_cnt), 0);

        // reset in the middle of an active line
        for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
        p0 = pop_n;
        enable = 1'b1;
        wait_fs();
        tick(17);
        chk("pre_rst_pops", pop_n - p0, 2);
        rd_rst = 1'b1;
        #1;
        chk("mrst_hs", 32'(lcd_hs), 1);
        chk("mrst_vs", 32'(lcd_vs), 1);
        chk("mrst_de", 32'(lcd_de), 0);
        chk("mrst_data", 32'(lcd_data), 0);
        chk("mrst_rd_en", 32'(fifo_rd_en), 0);
        chk("mrst_fs", 32'(frame_start), 0);
        chk("mrst_busy", 32'(busy), 0);
        enable = 1'b0;
        p0 = pop_n;
        tick(3);
        chk("rst_hold_pops", pop_n - p0, 0);
        rd_rst = 1'b0;
        tick(5);
        chk("post_rst_pops", pop_n - p0, 0);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_hs", 32'(lcd_hs), 1);
        obs_rd = obs_n;
        wp = rp;

        // saturation results from the parallel run
        k = 0;
        while (!sat_done && k < 80000) begin tick(1); k++; end
        chk("sat_done", 32'(sat_done), 1);
        chk("sat_reached", 32'(sat_hit), 1);
        chk("sat_hold", 32'(sat_final), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
